instruction_fetch_queue: RTL and testbench
==========================================

# instruction_fetch_queue

Decoupled instruction fetch stage that sits directly downstream of the program-counter stage and upstream of decode. Keeps its own fetch address and issues in-order reads to instruction memory. Buffers returned instructions, each tagged with its PC, in a small queue that decode drains with a valid/ready handshake. A taken branch from the PC stage redirects fetch, flushes the queue and discards every in-flight response.

## Interface
- DEPTH, 4, queue entries and the maximum number of in-flight plus buffered instructions; power of two, at least 2
- RESET_PC, 32'h0, first fetch address after reset
- clock  in  1  rising-edge clock for all state
- resetN  in  1  reset; one clock, synchronous, active-low
- redirect  in  1  taken branch or unconditional branch this cycle
- redirectTarget  in  32  new fetch address; must be word-aligned
- imemReqValid  out  1  read request valid
- imemReqReady  in  1  memory accepts the request
- imemReqAddr  out  32  read address
- imemRespValid  in  1  read data valid; in order, at least 1 cycle after acceptance, no backpressure
- imemRespData  in  32  instruction word
- instrValid  out  1  queue head valid
- instrReady  in  1  decode consumes the head
- instrData  out  32  head instruction
- instrPC  out  32  address of the head instruction

## Operation
- State registers:
  - fetchAddr: next request address.
  - respPC: PC of the next non-discarded response.
  - count: queue occupancy, 0..DEPTH.
  - outstanding: accepted requests with no response yet, 0..DEPTH.
  - dropCount: in-flight responses to discard, never more than outstanding.
  - run: cleared by reset, set the cycle after reset.
- reqFire = imemReqValid & imemReqReady. Only a cycle with valid and ready both high is a transfer. Memory must not rely on the address staying stable while valid is held.
- imemReqValid = run & !redirect & (count + outstanding < DEPTH). Doomed in-flight reads also consume credit, so the queue can never overflow.
- imemReqAddr = fetchAddr. On reqFire, fetchAddr increments by 4.
- Handling a response (imemRespValid):
  - If dropCount > 0: discard it and decrement dropCount.
  - Otherwise: push {respPC, imemRespData} and increment respPC by 4.
- outstanding_next = outstanding + reqFire - imemRespValid.
- instrValid = (count != 0). On instrValid & instrReady, pop the head.
- On redirect, all of the following take effect at the clock edge:
  - fetchAddr and respPC become redirectTarget.
  - The queue empties: count becomes 0, and a pop or push in the same cycle has no effect.
  - dropCount becomes outstanding - imemRespValid. A response in the redirect cycle is discarded.
- A response while outstanding == 0 is a protocol error: ignore it; the bench asserts it never occurs.
- All address arithmetic is modulo 2^32: 32'hFFFFFFFC + 4 wraps to 0.

## Timing
- Reset values, applied at the clock edge with resetN low:
  - imemReqValid 0, imemReqAddr RESET_PC.
  - instrValid 0, instrData 0, instrPC 0.
  - count, outstanding and dropCount 0; run 0.
- First request is presented in the second cycle after resetN rises.
- Response to decode latency: a response in cycle t is visible at the queue head in cycle t+1 when the queue was empty. There is no combinational bypass.
- Full-rate operation: one request accepted and one instruction popped per cycle, sustained whenever memory latency + 1 < DEPTH.
- Queue full with decode stalled: requests stop once count + outstanding reaches DEPTH. They resume in the cycle after the first pop.
- Combinational paths:
  - redirect to imemReqValid, so no request can carry a stale address.
  - No path from instrReady to any output.
- Reset asserted mid-operation: all state clears. Responses still in flight from before reset may arrive while outstanding == 0; they are ignored. The memory is reset with the same reset, so this does not occur in the system.

## Structure
- Shared package constants:
  - INSTR_W = 32
  - PC_W = 32
  - PC_INCR = 4
  - default RESET_PC
- Sub-module fetch_fifo: synchronous FIFO of width 64 ({pc, instr}) and depth DEPTH.
  - Inputs push, pop and clear.
  - Outputs count, head and empty.
  - clear has priority over push and pop.
- Request and response credit/drop logic lives in instruction_fetch_queue.

## Test plan
- Reset then free run: memory latency 1, always ready, instrReady=1, RESET_PC=0x100 -> requests 0x100, 0x104, 0x108 on consecutive cycles; instrPC sequence 0x100, 0x104, … one per cycle, instrData matching the memory contents.
- Backpressure: instrReady=0 for 10 cycles with DEPTH=4 -> exactly 4 requests accepted and count=4. Raise instrReady -> pops every cycle, no loss, next request issued in the cycle after the first pop.
- Redirect with 2 in flight: memory latency 3, redirect to 0x400 -> the 2 old responses are discarded; the next instrPC is 0x400 with mem[0x400]; no old-stream PC ever appears after the redirect.
- Redirect coinciding with a response and a pop: queue holds 2, imemRespValid=1, instrReady=1, redirect to 0x40 -> count=0 the next cycle, the response is discarded, dropCount = outstanding - 1, and imemReqValid is low in the redirect cycle.
- Address wrap: redirect to 0xFFFFFFF8 -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x0; instrPC follows the same values.
- Mid-run reset: resetN low for 1 cycle while count=3 -> the next cycle shows instrValid=0, imemReqValid=0, imemReqAddr=RESET_PC; fetch restarts from RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_queue_pkg.sv
// instruction_fetch_queue_pkg: shared widths, PC step, reset default and queue entry type
package instruction_fetch_queue_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] PC_INCR = 32'd4;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0;
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetchEntry_t;
endpackage

// File: rtl/instruction_fetch_queue_if.sv
// instruction_fetch_queue_if: instruction-memory request/response and decode-side handshake
interface instruction_fetch_queue_if;
    import instruction_fetch_queue_pkg::*;
    logic imemReqValid;
    logic imemReqReady;
    logic [PC_W-1:0] imemReqAddr;
    logic imemRespValid;
    logic [INSTR_W-1:0] imemRespData;
    logic instrValid;
    logic instrReady;
    logic [INSTR_W-1:0] instrData;
    logic [PC_W-1:0] instrPC;
    modport master (
        output imemReqValid, imemReqAddr, instrValid, instrData, instrPC,
        input imemReqReady, imemRespValid, imemRespData, instrReady
    );
    modport slave (
        input imemReqValid, imemReqAddr, instrValid, instrData, instrPC,
        output imemReqReady, imemRespValid, imemRespData, instrReady
    );
endinterface

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// fetch_fifo: synchronous {pc, instr} FIFO; clear wins over push and pop
module fetch_fifo
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic resetN,
    input  logic push,
    input  logic pop,
    input  logic clear,
    input  fetchEntry_t din,
    output logic [$clog2(DEPTH):0] count,
    output fetchEntry_t head,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    fetchEntry_t mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic doPush, doPop;
    assign empty = (count == '0);
    assign doPush = push & (count != CW'(DEPTH));
    assign doPop = pop & !empty;
    // Head is forced to zero when empty so reset shows clean data
    assign head = empty ? '0 : mem[rdPtr];
    always_ff @(posedge clock) begin
        if (!resetN || clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop) rdPtr <= rdPtr + AW'(1);
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end
    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= din;
    end
endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: decoupled fetch with credit-limited in-order reads, PC-tagged queue
// and redirect that flushes the queue and drops in-flight responses
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input logic clock,
    input logic resetN,
    input logic redirect,
    input logic [PC_W-1:0] redirectTarget,
    instruction_fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);
    logic [PC_W-1:0] fetchAddr, respPC;
    logic [CW-1:0] count, outstanding, dropCount;
    logic run, reqFire, respLive, drop, push, pop, empty;
    fetchEntry_t din, head;
    // Doomed in-flight reads still hold credit, so the queue can never overflow
    assign bus.imemReqValid = run & !redirect & ({1'b0, count} + {1'b0, outstanding} < CREDITS);
    assign bus.imemReqAddr = fetchAddr;
    assign reqFire = bus.imemReqValid & bus.imemReqReady;
    assign respLive = bus.imemRespValid & (outstanding != '0);
    assign drop = respLive & (dropCount != '0);
    assign push = respLive & !drop;
    assign pop = bus.instrValid & bus.instrReady;
    assign din = '{pc: respPC, instr: bus.imemRespData};
    assign bus.instrValid = !empty;
    assign bus.instrPC = head.pc;
    assign bus.instrData = head.instr;
    fetch_fifo #(.DEPTH(DEPTH)) fifo (
        .clock(clock),
        .resetN(resetN),
        .push(push),
        .pop(pop),
        .clear(redirect),
        .din(din),
        .count(count),
        .head(head),
        .empty(empty)
    );
    always_ff @(posedge clock) begin
        if (!resetN) begin
            fetchAddr <= RESET_PC;
            respPC <= RESET_PC;
            outstanding <= '0;
            dropCount <= '0;
            run <= 1'b0;
        end else begin
            run <= 1'b1;
            outstanding <= outstanding + CW'(reqFire) - CW'(respLive);
            fetchAddr <= redirect ? redirectTarget : reqFire ? fetchAddr + PC_INCR : fetchAddr;
            respPC <= redirect ? redirectTarget : push ? respPC + PC_INCR : respPC;
            // A response arriving with the redirect is itself doomed
            dropCount <= redirect ? outstanding - CW'(respLive) : dropCount - CW'(drop);
        end
    end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb_instruction_fetch_queue: randomized memory/decode traffic checked against an
// epoch-tagged queue model of the fetch stream
module tb_instruction_fetch_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] RPC = 32'h100;

    typedef struct { logic [31:0] addr; int epoch; int due; } memReq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } entry_t;

    logic clock = 1'b0;
    logic resetN = 1'b0;
    logic redirect = 1'b0;
    logic [31:0] redirectTarget = '0;
    always #5 clock = ~clock;

    instruction_fetch_queue_if bus();
    instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clock(clock),
        .resetN(resetN),
        .redirect(redirect),
        .redirectTarget(redirectTarget),
        .bus(bus)
    );

    memReq_t memQ[$];
    entry_t modelQ[$];
    int compared = 0, mismatched = 0, cyc = 0, epoch = 0, lastDue = 0;
    int pReq = 100, pInstr = 100, pRedir = 0, latMin = 1, latMax = 1;
    logic [31:0] mFetch = RPC;
    bit mRun = 0, armCoincide = 0, armReset = 0, hitCoincide = 0, hitReset = 0;

    function automatic logic [31:0] memFn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs after negedge, check, then advance the model at posedge
    task automatic tick(input bit forceRedir = 0, input logic [31:0] forceTgt = '0);
        memReq_t r;
        bit resp, fire, pop, redir, rst, expValid;
        logic [31:0] tgt;
        int cur, lat, due;
        cur = cyc;
        resp = memQ.size() != 0 && memQ[0].due <= cur;
        bus.imemRespValid = resp;
        bus.imemRespData = resp ? memFn(memQ[0].addr) : $urandom;
        bus.imemReqReady = $urandom_range(99) < pReq;
        bus.instrReady = $urandom_range(99) < pInstr;
        redir = forceRedir || ($urandom_range(99) < pRedir);
        tgt = forceRedir ? forceTgt
            : ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 4
            : 32'($urandom_range(1023)) << 2;
        if (armCoincide && modelQ.size() == 2 && resp) begin
            redir = 1;
            tgt = 32'h40;
            bus.instrReady = 1;
            armCoincide = 0;
            hitCoincide = 1;
        end
        rst = armReset && modelQ.size() == 3;
        if (rst) begin
            armReset = 0;
            hitReset = 1;
            redir = 0;
        end
        resetN = !rst;
        redirect = redir;
        redirectTarget = tgt;
        #1;
        expValid = mRun && !redir && (modelQ.size() + memQ.size() < DEPTH);
        checkEq("reqValid", 32'(bus.imemReqValid), 32'(expValid));
        checkEq("reqAddr", bus.imemReqAddr, mFetch);
        checkEq("instrValid", 32'(bus.instrValid), 32'(modelQ.size() != 0));
        if (modelQ.size() != 0) begin
            checkEq("instrPC", bus.instrPC, modelQ[0].pc);
            checkEq("instrData", bus.instrData, modelQ[0].data);
        end
        fire = bus.imemReqValid && bus.imemReqReady;
        pop = modelQ.size() != 0 && bus.instrReady;
        @(posedge clock);
        cyc++;
        if (rst) begin
            memQ.delete();
            modelQ.delete();
            mFetch = RPC;
            mRun = 0;
            epoch++;
        end else begin
            mRun = 1;
            if (resp) r = memQ.pop_front();
            if (redir) begin
                modelQ.delete();
                epoch++;
                mFetch = tgt;
            end else begin
                if (pop) void'(modelQ.pop_front());
                if (resp && r.epoch == epoch) modelQ.push_back('{r.addr, memFn(r.addr)});
            end
            if (fire) begin
                lat = $urandom_range(latMax, latMin);
                due = (cur + lat > lastDue + 1) ? cur + lat : lastDue + 1;
                lastDue = due;
                memQ.push_back('{bus.imemReqAddr, epoch, due});
                mFetch += 4;
            end
        end
        @(negedge clock);
    endtask

    initial begin
        bus.imemReqReady = 0;
        bus.imemRespValid = 0;
        bus.imemRespData = '0;
        bus.instrReady = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetN = 1;
        #1;
        checkEq("rstReqValid", 32'(bus.imemReqValid), 0);
        checkEq("rstReqAddr", bus.imemReqAddr, RPC);
        checkEq("rstInstrValid", 32'(bus.instrValid), 0);
        checkEq("rstInstrData", bus.instrData, 0);
        checkEq("rstInstrPC", bus.instrPC, 0);
        // free run, latency 1
        repeat (20) tick();
        // decode stall then release
        pInstr = 0;
        repeat (10) tick();
        pInstr = 100;
        repeat (10) tick();
        // redirect with reads in flight
        latMin = 3; latMax = 3;
        repeat (8) tick();
        tick(1, 32'h400);
        repeat (15) tick();
        // redirect landing with a response and a pop
        latMin = 2; latMax = 2; pInstr = 0; armCoincide = 1;
        for (int i = 0; i < 40 && armCoincide; i++) tick();
        pInstr = 100;
        repeat (10) tick();
        // address wrap
        latMin = 1; latMax = 1;
        tick(1, 32'hFFFF_FFF8);
        repeat (10) tick();
        // mid-run reset with three queued
        pInstr = 0; armReset = 1;
        for (int i = 0; i < 40 && armReset; i++) tick();
        pInstr = 100;
        repeat (10) tick();
        checkEq("coincideHit", 32'(hitCoincide), 1);
        checkEq("resetHit", 32'(hitReset), 1);
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                pReq = $urandom_range(100, 20);
                pInstr = $urandom_range(100, 10);
                pRedir = $urandom_range(8);
                latMin = $urandom_range(3, 1);
                latMax = latMin + $urandom_range(3);
            end
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
